// File: rtl/ex_operand_stage_pkg.sv
// Shared CPU definitions for the execute-stage operand path: field widths,
// the ID/EX pipeline register layout, its bubble value and the forward-hit test.
package ex_operand_stage_pkg;

  localparam int XLEN      = 32;
  localparam int ALU_CTL_W = 5;
  localparam int REG_IDX_W = 5;
  localparam int SHAMT_W   = 5;

  typedef logic [XLEN-1:0]      word_t;
  typedef logic [ALU_CTL_W-1:0] alu_ctl_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [SHAMT_W-1:0]   shamt_t;

  // ID/EX pipeline register contents.
  typedef struct packed {
    logic     valid;
    word_t    rs_data;
    word_t    rt_data;
    word_t    imm;
    shamt_t   shamt;
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t rd;
    alu_ctl_t alu_ctl;
    logic     sign;
    logic     alusrc1;
    logic     alusrc2;
    logic     reg_write;
    logic     mem_read;
  } idex_t;

  // A bubble is a fully cleared register: invalid, no side effects, ALUCtl 0,
  // and zeroed data so nothing stale leaks into the ALU inputs.
  localparam idex_t IDEX_BUBBLE = '0;

  // A later stage supplies a source operand when it writes a nonzero
  // destination that equals that source; register 0 is hardwired and never forwarded.
  function automatic logic fwd_hit(input logic we, input reg_idx_t dst, input reg_idx_t src);
    return we && (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Single-operand forwarding selector: EX/MEM result, then MEM/WB result,
// then the value read from the register file.
module fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  reg_idx_t i_src,
  input  word_t    i_reg_data,
  input  logic     i_mem_reg_write,
  input  reg_idx_t i_mem_rd,
  input  word_t    i_mem_data,
  input  logic     i_wb_reg_write,
  input  reg_idx_t i_wb_rd,
  input  word_t    i_wb_data,
  output word_t    o_data
);

  // Pick the youngest in-flight producer of i_src, else the registered value.
  always_comb begin
    // NOTE: default first so every path assigns o_data and no latch is inferred.
    o_data = i_reg_data;
    if (FWD_EN) begin
      if (fwd_hit(i_mem_reg_write, i_mem_rd, i_src)) begin
        o_data = i_mem_data;
      end else if (fwd_hit(i_wb_reg_write, i_wb_rd, i_src)) begin
        o_data = i_wb_data;
      end
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with bubble/stall control, load-use hazard
// detection and operand forwarding into the ALU inputs.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_rs_data,
  input  logic [XLEN-1:0]      id_rt_data,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [SHAMT_W-1:0]   id_shamt,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [ALU_CTL_W-1:0] id_alu_ctl,
  input  logic                 id_sign,
  input  logic                 id_alusrc1,
  input  logic                 id_alusrc2,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 mem_reg_write,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic [XLEN-1:0]      alu_in1,
  output logic [XLEN-1:0]      alu_in2,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 alu_sign,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic [XLEN-1:0]      ex_store_data,
  output logic                 ex_valid,
  output logic                 load_use_stall
);

  idex_t r_idex;
  idex_t w_idex_nxt;
  idex_t w_id_fields;
  logic  w_load_use;
  word_t w_fwd_a;
  word_t w_fwd_b;

  assign w_id_fields = '{
    valid:     id_valid,
    rs_data:   id_rs_data,
    rt_data:   id_rt_data,
    imm:       id_imm,
    shamt:     id_shamt,
    rs:        id_rs,
    rt:        id_rt,
    rd:        id_rd,
    alu_ctl:   id_alu_ctl,
    sign:      id_sign,
    alusrc1:   id_alusrc1,
    alusrc2:   id_alusrc2,
    reg_write: id_reg_write,
    mem_read:  id_mem_read
  };

  // A load in EX whose destination feeds the instruction in ID cannot be
  // forwarded in time; the ID instruction must wait one cycle.
  assign w_load_use = r_idex.valid && r_idex.mem_read && (r_idex.rd != '0) &&
                      ((r_idex.rd == id_rs) || (r_idex.rd == id_rt));

  // Next register value: flush beats stall beats load-use bubble beats load.
  always_comb begin
    w_idex_nxt = w_id_fields;
    if (flush) begin
      w_idex_nxt = IDEX_BUBBLE;
    end else if (stall) begin
      w_idex_nxt = r_idex;
    end else if (w_load_use) begin
      w_idex_nxt = IDEX_BUBBLE;
    end
  end

  // ID/EX register; reset clears it immediately, discarding any held instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idex <= IDEX_BUBBLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      r_idex <= w_idex_nxt;
    end
  end

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_a (
    .i_src           (r_idex.rs),
    .i_reg_data      (r_idex.rs_data),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_rd        (mem_rd),
    .i_mem_data      (mem_data),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_data       (wb_data),
    .o_data          (w_fwd_a)
  );

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_b (
    .i_src           (r_idex.rt),
    .i_reg_data      (r_idex.rt_data),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_rd        (mem_rd),
    .i_mem_data      (mem_data),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_data       (wb_data),
    .o_data          (w_fwd_b)
  );

  // Shift amount goes on in1 (ALU shifts by in1[4:0]); immediate goes on in2.
  assign alu_in1        = r_idex.alusrc1 ? {{(XLEN-SHAMT_W){1'b0}}, r_idex.shamt} : w_fwd_a;
  assign alu_in2        = r_idex.alusrc2 ? r_idex.imm : w_fwd_b;
  assign ex_store_data  = w_fwd_b;
  assign alu_ctl        = r_idex.alu_ctl;
  assign alu_sign       = r_idex.sign;
  assign ex_rd          = r_idex.rd;
  assign ex_reg_write   = r_idex.reg_write;
  assign ex_mem_read    = r_idex.mem_read;
  assign ex_valid       = r_idex.valid;
  assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: a vector table drives the ID
// inputs before an edge and the forward sources after it; expected outputs
// go through a scoreboard queue. A FWD_EN=0 twin checks the gated path.
module tb_ex_operand_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd, id_alu_ctl;
  logic        id_sign, id_alusrc1, id_alusrc2, id_reg_write, id_mem_read;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;

  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [4:0]  alu_ctl, ex_rd;
  logic        alu_sign, ex_reg_write, ex_mem_read, ex_valid, load_use_stall;

  logic [31:0] nf_alu_in1, nf_alu_in2, nf_ex_store_data;
  logic [4:0]  nf_alu_ctl, nf_ex_rd;
  logic        nf_alu_sign, nf_ex_reg_write, nf_ex_mem_read, nf_ex_valid, nf_load_use_stall;

  ex_operand_stage #(.FWD_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_alu_ctl(id_alu_ctl), .id_sign(id_sign),
    .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl), .alu_sign(alu_sign),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid),
    .load_use_stall(load_use_stall)
  );

  ex_operand_stage #(.FWD_EN(1'b0)) u_dut_nf (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_alu_ctl(id_alu_ctl), .id_sign(id_sign),
    .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_in1(nf_alu_in1), .alu_in2(nf_alu_in2), .alu_ctl(nf_alu_ctl),
    .alu_sign(nf_alu_sign), .ex_rd(nf_ex_rd), .ex_reg_write(nf_ex_reg_write),
    .ex_mem_read(nf_ex_mem_read), .ex_store_data(nf_ex_store_data),
    .ex_valid(nf_ex_valid), .load_use_stall(nf_load_use_stall)
  );

  typedef struct packed {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [4:0]  ctl;
    logic        sign;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [31:0] sd;
    logic        v;
    logic        lus;
  } out_t;

  typedef struct {
    logic        stall, flush;
    logic [4:0]  rs, rt, rd, ctl, sh;
    logic [31:0] rsd, rtd, imm;
    logic        sign, src1, src2, rw, mr;
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic [4:0]  prs, prt;
    out_t        exp;
    logic [31:0] nf_a1, nf_a2;
  } vec_t;

  localparam logic [31:0] F_MR   = 32'h01;
  localparam logic [31:0] F_RW   = 32'h02;
  localparam logic [31:0] F_SRC2 = 32'h04;
  localparam logic [31:0] F_SRC1 = 32'h08;
  localparam logic [31:0] F_SGN  = 32'h10;

  int   n_vec = 0;
  int   n_bad = 0;
  out_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] rs, input logic [31:0] rsd,
                              input logic [31:0] rt, input logic [31:0] rtd,
                              input logic [31:0] imm, input logic [31:0] sh,
                              input logic [31:0] rd, input logic [31:0] ctl,
                              input logic [31:0] flags);
    vec_t v;
    v.stall = 1'b0; v.flush = 1'b0;
    v.rs = rs[4:0]; v.rsd = rsd; v.rt = rt[4:0]; v.rtd = rtd;
    v.imm = imm; v.sh = sh[4:0]; v.rd = rd[4:0]; v.ctl = ctl[4:0];
    v.sign = flags[4]; v.src1 = flags[3]; v.src2 = flags[2];
    v.rw = flags[1]; v.mr = flags[0];
    v.mrw = 1'b0; v.mrd = '0; v.mdata = '0;
    v.wrw = 1'b0; v.wrd = '0; v.wdata = '0;
    v.prs = '0; v.prt = '0;
    v.exp = '0; v.nf_a1 = '0; v.nf_a2 = '0;
    return v;
  endfunction

  function automatic vec_t fw(input vec_t vi, input logic [31:0] mrw, input logic [31:0] mrd,
                              input logic [31:0] mdata, input logic [31:0] wrw,
                              input logic [31:0] wrd, input logic [31:0] wdata);
    vec_t v = vi;
    v.mrw = mrw[0]; v.mrd = mrd[4:0]; v.mdata = mdata;
    v.wrw = wrw[0]; v.wrd = wrd[4:0]; v.wdata = wdata;
    return v;
  endfunction

  function automatic out_t eo(input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] ctl, input logic [31:0] sign,
                              input logic [31:0] rd, input logic [31:0] rw,
                              input logic [31:0] mr, input logic [31:0] sd,
                              input logic [31:0] v, input logic [31:0] lus);
    out_t o;
    o.a1 = a1; o.a2 = a2; o.ctl = ctl[4:0]; o.sign = sign[0]; o.rd = rd[4:0];
    o.rw = rw[0]; o.mr = mr[0]; o.sd = sd; o.v = v[0]; o.lus = lus[0];
    return o;
  endfunction

  function automatic out_t sample();
    return {alu_in1, alu_in2, alu_ctl, alu_sign, ex_rd, ex_reg_write,
            ex_mem_read, ex_store_data, ex_valid, load_use_stall};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive ID side before the edge, forward sources after it, then compare.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    stall = v.stall; flush = v.flush; id_valid = 1'b1;
    id_rs = v.rs; id_rs_data = v.rsd; id_rt = v.rt; id_rt_data = v.rtd;
    id_imm = v.imm; id_shamt = v.sh; id_rd = v.rd; id_alu_ctl = v.ctl;
    id_sign = v.sign; id_alusrc1 = v.src1; id_alusrc2 = v.src2;
    id_reg_write = v.rw; id_mem_read = v.mr;
    sb.push_back(v.exp);
    @(posedge clk);
    #2;
    mem_reg_write = v.mrw; mem_rd = v.mrd; mem_data = v.mdata;
    wb_reg_write = v.wrw; wb_rd = v.wrd; wb_data = v.wdata;
    id_rs = v.prs; id_rt = v.prt;
    #1;
    check(name, 128'(sample()), 128'(sb.pop_front()));
    check({name, "_nofwd"}, {64'h0, nf_alu_in1, nf_alu_in2}, {64'h0, v.nf_a1, v.nf_a2});
  endtask

  initial begin
    vec_t v;
    vec_t held;

    reset = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_alu_ctl = '0; id_sign = 1'b0;
    id_alusrc1 = 1'b0; id_alusrc2 = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_data = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;

    // vec0: plain add, no forwarding
    v = mk(3, 'h111, 4, 'h222, 0, 0, 3, 2, F_SGN | F_RW);
    v.exp = eo('h111, 'h222, 2, 1, 3, 1, 0, 'h222, 1, 0); v.nf_a1 = 'h111; v.nf_a2 = 'h222; tbl.push_back(v);
    // vec1: back-to-back dependence on r3 forwarded from EX/MEM
    v = fw(mk(3, 'h5, 0, 0, 0, 0, 6, 2, F_RW), 1, 3, 'h10, 0, 0, 0);
    v.exp = eo('h10, 0, 2, 0, 6, 1, 0, 0, 1, 0); v.nf_a1 = 'h5; v.nf_a2 = 0; tbl.push_back(v);
    // vec2: both stages write r5; EX/MEM wins
    v = fw(mk(1, 'hAAAA, 5, 'h77, 0, 0, 8, 3, F_RW), 1, 5, 1, 1, 5, 2);
    v.exp = eo('hAAAA, 1, 3, 0, 8, 1, 0, 1, 1, 0); v.nf_a1 = 'hAAAA; v.nf_a2 = 'h77; tbl.push_back(v);
    // vec3: A from MEM/WB, B from EX/MEM
    v = fw(mk(9, 'h99, 5, 'h55, 0, 0, 10, 2, F_RW), 1, 5, 'h1234, 1, 9, 'hBEEF);
    v.exp = eo('hBEEF, 'h1234, 2, 0, 10, 1, 0, 'h1234, 1, 0); v.nf_a1 = 'h99; v.nf_a2 = 'h55; tbl.push_back(v);
    // vec4: r0 with writes to rd=0 in flight: registered value passes through
    v = fw(mk(0, 'hDEAD, 0, 'hC0DE, 0, 0, 11, 2, F_RW), 1, 0, 1, 1, 0, 2);
    v.exp = eo('hDEAD, 'hC0DE, 2, 0, 11, 1, 0, 'hC0DE, 1, 0); v.nf_a1 = 'hDEAD; v.nf_a2 = 'hC0DE; tbl.push_back(v);
    // vec5: matching rd but write enables low
    v = fw(mk(12, 'h12, 13, 'h13, 0, 0, 14, 2, F_RW), 0, 12, 'hFF, 0, 13, 'hEE);
    v.exp = eo('h12, 'h13, 2, 0, 14, 1, 0, 'h13, 1, 0); v.nf_a1 = 'h12; v.nf_a2 = 'h13; tbl.push_back(v);
    // vec6: sll by 4, rt forwarded
    v = fw(mk(0, 'h9999, 15, 'h1, 'h3333, 4, 16, 8, F_SRC1 | F_RW), 1, 15, 'hF0F0, 0, 0, 0);
    v.exp = eo(4, 'hF0F0, 8, 0, 16, 1, 0, 'hF0F0, 1, 0); v.nf_a1 = 4; v.nf_a2 = 1; tbl.push_back(v);
    // vec7: immediate on in2, store data still forwarded B
    v = fw(mk(17, 'h100, 18, 'h200, 'hFFFFFFF0, 0, 18, 2, F_SRC2 | F_RW), 0, 0, 0, 1, 18, 'h3030);
    v.exp = eo('h100, 'hFFFFFFF0, 2, 0, 18, 1, 0, 'h3030, 1, 0); v.nf_a1 = 'h100; v.nf_a2 = 'hFFFFFFF0; tbl.push_back(v);
    // vec8: load to r7; ID now shows rs=7 -> hazard flagged
    v = mk(19, 'h40, 0, 0, 4, 0, 7, 2, F_SRC2 | F_RW | F_MR); v.prs = 7;
    v.exp = eo('h40, 4, 2, 0, 7, 1, 1, 0, 1, 1); v.nf_a1 = 'h40; v.nf_a2 = 4; tbl.push_back(v);
    // vec9: dependent instruction -> bubble
    v = mk(7, 'h1, 0, 0, 0, 0, 20, 2, F_RW);
    v.exp = '0; tbl.push_back(v);
    // vec10: replayed instruction gets the load result from MEM/WB
    v = fw(mk(7, 'h1, 0, 0, 0, 0, 20, 2, F_RW), 0, 0, 0, 1, 7, 'h4444);
    v.exp = eo('h4444, 0, 2, 0, 20, 1, 0, 0, 1, 0); v.nf_a1 = 'h1; v.nf_a2 = 0; tbl.push_back(v);
    // vec11: flush and stall together -> bubble
    v = mk(21, 'h21, 0, 0, 0, 0, 21, 2, F_RW); v.stall = 1'b1; v.flush = 1'b1;
    v.exp = '0; tbl.push_back(v);
    // vec12: load to r22
    v = mk(2, 'h20, 0, 0, 8, 0, 22, 2, F_SRC2 | F_RW | F_MR);
    v.exp = eo('h20, 8, 2, 0, 22, 1, 1, 0, 1, 0); v.nf_a1 = 'h20; v.nf_a2 = 8; tbl.push_back(v);
    // vec13: stall with dependent ID: hold wins over load-use
    v = mk(22, 'h1, 0, 0, 0, 0, 23, 2, F_RW); v.stall = 1'b1; v.prs = 22;
    v.exp = eo('h20, 8, 2, 0, 22, 1, 1, 0, 1, 1); v.nf_a1 = 'h20; v.nf_a2 = 8; tbl.push_back(v);
    // vec14: stall drops, load-use takes effect
    v = mk(22, 'h1, 0, 0, 0, 0, 23, 2, F_RW);
    v.exp = '0; tbl.push_back(v);
    // vec15: instruction to be held by the stall sequence below
    v = mk(24, 'h2424, 25, 'h2525, 0, 0, 26, 4, F_RW);
    v.exp = eo('h2424, 'h2525, 4, 0, 26, 1, 0, 'h2525, 1, 0); v.nf_a1 = 'h2424; v.nf_a2 = 'h2525; tbl.push_back(v);

    #3;
    check("reset_state", 128'(sample()), 128'(0));
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Three stall cycles with changing ID inputs: outputs stay at vec15
    held = mk(27, 'hFFFF, 28, 'hEEEE, 1, 3, 29, 9, F_SRC1 | F_SRC2 | F_MR);
    held.stall = 1'b1;
    held.exp = tbl[15].exp; held.nf_a1 = 'h2424; held.nf_a2 = 'h2525;
    for (int k = 0; k < 3; k++) begin
      apply(held, $sformatf("stall%0d", k));
    end

    // Async reset mid-cycle while stalled: outputs clear before the next edge
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset", 128'(sample()), 128'(0));
    check("async_reset_nofwd", {64'h0, nf_alu_in1, nf_alu_in2}, 128'(0));

    // Release between edges; the first edge afterwards loads normally
    @(posedge clk);
    #1 reset = 1'b1; stall = 1'b0;
    v = mk(30, 'h3030, 31, 'h3131, 0, 0, 1, 6, F_RW | F_SGN);
    v.exp = eo('h3030, 'h3131, 6, 1, 1, 1, 0, 'h3131, 1, 0); v.nf_a1 = 'h3030; v.nf_a2 = 'h3131;
    apply(v, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
